// File: rtl/rtc_bus_if.sv
// Request and multiplexed address/data bus signals between the RTC
// controllers / pad ring and the bus driver.
interface rtc_bus_if;
  logic       activa;
  logic       escribe;
  logic       lee;
  logic [7:0] dir_in;
  logic [7:0] data_in;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       a_d;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] data_read;
  logic       fin;

  modport master (
    output activa, escribe, lee, dir_in, data_in, ad_in,
    input  ad_out, ad_oe, cs_n, a_d, wr_n, rd_n, data_read, fin
  );

  modport slave (
    input  activa, escribe, lee, dir_in, data_in, ad_in,
    output ad_out, ad_oe, cs_n, a_d, wr_n, rd_n, data_read, fin
  );
endinterface

// File: rtl/rtc_bus_driver.sv
// Drives one RTC register access on the multiplexed bus: timed address phase,
// gap, data phase, then a one-cycle fin pulse.
//
// state   | meaning
// IDLE    | waiting for a request
// ADDR_LO | address driven, wr_n low
// ADDR_HI | address driven, wr_n high
// GAP     | bus released, cs_n high (turnaround before a read)
// DATA_LO | data phase, wr_n or rd_n low
// DATA_HI | data phase, strobes high
// DONE    | fin pulse
// REARM   | wait for the controller to drop or change its request
module rtc_bus_driver #(
  parameter int T_PHASE = 5
) (
  input  logic      clk,
  input  logic      reset,
  rtc_bus_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR_LO = 3'd1;
  localparam logic [2:0] ADDR_HI = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] DATA_LO = 3'd4;
  localparam logic [2:0] DATA_HI = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] REARM   = 3'd7;

  localparam logic [7:0] LAST = 8'(T_PHASE - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [7:0]  lat_dir;
  logic [7:0]  lat_data;
  logic        lat_esc;
  logic        lat_lee;
  logic        is_wr;
  logic        last;
  logic        req_changed;

  assign last        = (cnt == LAST);
  assign req_changed = ({bus.dir_in, bus.data_in, bus.escribe, bus.lee} !=
                        {lat_dir, lat_data, lat_esc, lat_lee});

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      lat_dir       <= 8'd0;
      lat_data      <= 8'd0;
      lat_esc       <= 1'b0;
      lat_lee       <= 1'b0;
      is_wr         <= 1'b0;
      bus.ad_out    <= 8'd0;
      bus.ad_oe     <= 1'b0;
      bus.cs_n      <= 1'b1;
      bus.a_d       <= 1'b0;
      bus.wr_n      <= 1'b1;
      bus.rd_n      <= 1'b1;
      bus.data_read <= 8'd0;
      bus.fin       <= 1'b0;
    end else begin
      bus.fin <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (bus.activa && (bus.escribe || bus.lee)) begin
            lat_dir    <= bus.dir_in;
            lat_data   <= bus.data_in;
            lat_esc    <= bus.escribe;
            lat_lee    <= bus.lee;
            is_wr      <= bus.escribe;
            state      <= ADDR_LO;
            bus.cs_n   <= 1'b0;
            bus.a_d    <= 1'b0;
            bus.ad_oe  <= 1'b1;
            bus.ad_out <= bus.dir_in;
            bus.wr_n   <= 1'b0;
          end
        end
        ADDR_LO: begin
          if (last) begin
            state    <= ADDR_HI;
            cnt      <= 8'd0;
            bus.wr_n <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ADDR_HI: begin
          if (last) begin
            state      <= GAP;
            cnt        <= 8'd0;
            bus.cs_n   <= 1'b1;
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (last) begin
            state    <= DATA_LO;
            cnt      <= 8'd0;
            bus.cs_n <= 1'b0;
            bus.a_d  <= 1'b1;
            if (is_wr) begin
              bus.ad_oe  <= 1'b1;
              bus.ad_out <= lat_data;
              bus.wr_n   <= 1'b0;
            end else begin
              bus.rd_n <= 1'b0;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA_LO: begin
          if (last) begin
            state    <= DATA_HI;
            cnt      <= 8'd0;
            bus.wr_n <= 1'b1;
            bus.rd_n <= 1'b1;
            if (!is_wr) bus.data_read <= bus.ad_in;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DATA_HI: begin
          if (last) begin
            state      <= DONE;
            cnt        <= 8'd0;
            bus.fin    <= 1'b1;
            bus.cs_n   <= 1'b1;
            bus.ad_oe  <= 1'b0;
            bus.a_d    <= 1'b0;
            bus.ad_out <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= REARM;
          cnt   <= 8'd0;
        end
        REARM: begin
          cnt <= 8'd0;
          // a request still held unchanged after fin must not be replayed
          if (!bus.activa || req_changed) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Directed bench for rtc_bus_driver with T_PHASE=5: cycle-by-cycle bus
// waveform checks for writes, reads, transfer commands and mid-access reset.
module tb_rtc_bus_driver;

  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;
  logic [7:0] prev_dr = 8'd0;

  rtc_bus_if bus ();

  rtc_bus_driver #(.T_PHASE(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {cs_n, a_d, ad_oe, wr_n, rd_n, fin, ad_out}
  function automatic logic [13:0] obs();
    return {bus.cs_n, bus.a_d, bus.ad_oe, bus.wr_n, bus.rd_n, bus.fin, bus.ad_out};
  endfunction

  localparam logic [13:0] IDLE_V = {6'b100110, 8'h00};

  // Expected bus levels for cycle c (1 = cycle after the acceptance edge), T_PHASE=5.
  function automatic logic [13:0] exp_vec(input int c, input logic wr,
                                          input logic [7:0] dir, input logic [7:0] dat);
    if (c <= 5)  return {6'b001010, dir};
    if (c <= 10) return {6'b001110, dir};
    if (c <= 15) return {6'b100110, 8'h00};
    if (c <= 20) return wr ? {6'b011010, dat} : {6'b010100, 8'h00};
    if (c <= 25) return wr ? {6'b011110, dat} : {6'b010110, 8'h00};
    if (c == 26) return {6'b100111, 8'h00};
    return IDLE_V;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request and wait (bounded) for cs_n to fall; returns 1 on start.
  task automatic start_req(input logic [7:0] dir, input logic [7:0] dat,
                           input logic esc, input logic le, output bit ok);
    bus.activa  = 1'b1;
    bus.dir_in  = dir;
    bus.data_in = dat;
    bus.escribe = esc;
    bus.lee     = le;
    ok = 1'b0;
    for (int w = 0; w < 10; w++) begin
      step();
      if (bus.cs_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("start %0h", dir), 32'(bus.cs_n), 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] dir, input logic [7:0] dat,
                         input logic esc, input logic le, input logic [7:0] rdval);
    bit ok;
    logic wr;
    wr = esc;
    bus.ad_in = 8'hEE;
    start_req(dir, dat, esc, le, ok);
    if (!ok) return;
    for (int c = 1; c <= 29; c++) begin
      chk($sformatf("txn %0h c%0d", dir, c), 32'(obs()), 32'(exp_vec(c, wr, dir, dat)));
      if (c == 20) chk($sformatf("dr_hold %0h", dir), 32'(bus.data_read), 32'(prev_dr));
      if (c == 21 && !wr) begin
        prev_dr = rdval;
        chk($sformatf("dr_new %0h", dir), 32'(bus.data_read), 32'(rdval));
      end
      bus.ad_in = (c >= 15 && c <= 20) ? rdval : 8'hEE;
      if (c < 29) step();
    end
  endtask

  task automatic count_hold(input string tag, input int cycles);
    int lows = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.cs_n !== 1'b1 || bus.wr_n !== 1'b1 || bus.rd_n !== 1'b1 || bus.fin !== 1'b0)
        lows++;
    end
    chk(tag, 32'(lows), 32'd0);
  endtask

  initial begin
    bit ok;
    reset       = 1'b1;
    bus.activa  = 1'b0;
    bus.escribe = 1'b0;
    bus.lee     = 1'b0;
    bus.dir_in  = 8'h00;
    bus.data_in = 8'h00;
    bus.ad_in   = 8'hEE;
    step();
    chk("reset bus", 32'(obs()), 32'(IDLE_V));
    chk("reset dr", 32'(bus.data_read), 32'd0);
    step();
    reset = 1'b0;
    count_hold("idle strobes", 20);

    run_txn(8'h21, 8'h45, 1'b1, 1'b0, 8'h00);
    count_hold("held no reissue", 20);

    run_txn(8'hF0, 8'hF0, 1'b1, 1'b0, 8'h00);
    count_hold("f0 held", 10);
    bus.activa = 1'b0;
    count_hold("drop activa", 3);

    run_txn(8'h42, 8'h00, 1'b0, 1'b1, 8'h37);
    chk("read result", 32'(bus.data_read), 32'h37);
    bus.activa = 1'b0;
    count_hold("after read", 3);

    run_txn(8'h43, 8'h10, 1'b1, 1'b1, 8'h00);
    chk("both keeps dr", 32'(bus.data_read), 32'h37);
    bus.activa = 1'b0;
    count_hold("after both", 3);

    // reset in DATA_LO of a write
    start_req(8'h55, 8'h66, 1'b1, 1'b0, ok);
    if (ok) begin
      for (int c = 2; c <= 17; c++) step();
      chk("pre-reset dlo", 32'(obs()), 32'(exp_vec(17, 1'b1, 8'h55, 8'h66)));
      reset = 1'b1;
      step();
      chk("abort bus", 32'(obs()), 32'(IDLE_V));
      chk("abort dr", 32'(bus.data_read), 32'd0);
      prev_dr = 8'd0;
      reset      = 1'b0;
      bus.activa = 1'b0;
      count_hold("no fin after abort", 30);
      run_txn(8'h12, 8'h34, 1'b1, 1'b0, 8'h00);
      bus.activa = 1'b0;
      count_hold("after recovery", 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_bus_driver.md
Name: rtc_bus_driver

Overview:
- Physical-bus stage directly downstream of the RTC write controller and the companion read controller.
- Accepts one register access request (address, data, write/read) and drives the RTC's multiplexed address/data bus through a timed address phase followed by a data phase.
- Signals completion with a one-cycle `fin` pulse, which the controllers use to advance their state machines.
- Covers plain register writes and the 0xF0/0xF2 transfer commands the write controller issues after time and timer writes.

Parameters:
T_PHASE, 5, clk cycles per bus phase (strobe-low and strobe-high widths, inter-phase gap); legal range 1..255

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
activa  in  1  request valid from controller
escribe  in  1  write request (qualified by activa)
lee  in  1  read request (qualified by activa)
dir_in  in  8  RTC register address
data_in  in  8  write data
ad_in  in  8  bus value sampled from pad (read data)
ad_out  out  8  value driven onto bus when ad_oe=1
ad_oe  out  1  bus output enable (1 = drive)
cs_n  out  1  chip select, active low
a_d  out  1  0 = address phase, 1 = data phase
wr_n  out  1  write strobe, active low
rd_n  out  1  read strobe, active low
data_read  out  8  last read result, held until next read completes
fin  out  1  transaction complete, one-cycle pulse

Behaviour:
- All outputs registered. Reset values, applied at the first clk edge with reset=1: ad_out=0, ad_oe=0, cs_n=1, a_d=0, wr_n=1, rd_n=1, data_read=0, fin=0, state=IDLE, phase counter=0.
- Reset mid-transaction aborts the transaction. No `fin` is produced, and the bus returns to idle levels at that edge.
- Request accepted in IDLE when activa=1 and (escribe=1 or lee=1). If escribe and lee are both 1, a write is performed.
- On acceptance, dir_in, data_in and the write/read type are latched. Later input changes have no effect until the transaction ends.
- States, each lasting T_PHASE cycles on an internal counter unless noted:
  - ADDR_LO: cs_n=0, a_d=0, ad_oe=1, ad_out=latched dir, wr_n=0.
  - ADDR_HI: same as ADDR_LO but wr_n=1.
  - GAP: cs_n=1, ad_oe=0, ad_out=0.
  - DATA_LO:
    - Write: cs_n=0, a_d=1, ad_oe=1, ad_out=latched data, wr_n=0.
    - Read: cs_n=0, a_d=1, ad_oe=0, rd_n=0. data_read <= ad_in on the last cycle of this state.
  - DATA_HI: same as DATA_LO but wr_n=1 and rd_n=1; data stays driven for a write.
  - DONE: 1 cycle. fin=1, cs_n=1, ad_oe=0, a_d=0, ad_out=0. Then go to REARM.
  - REARM: fin=0, bus idle. Go to IDLE when activa=0, or when {dir_in,data_in,escribe,lee} differs from the latched copy. This prevents re-issuing a request the controller is still holding after `fin`.
- Latency: cs_n falls on the acceptance edge. fin is high for exactly one cycle, 5*T_PHASE+1 edges after acceptance (26 for T_PHASE=5).
- Address is strobed on a wr_n pulse for both reads and writes.
- Bus contention rule: ad_oe=0 at least T_PHASE cycles before rd_n falls, and is never 1 while rd_n=0.
- Phase counter width is 8 bits; it reloads to 0 at every state change and never wraps inside a state.
- data_read changes only at the end of DATA_LO of a read.

Test Plan:
- Reset, then idle: all outputs at reset values; with activa=0 for 20 cycles there are no strobes.
- Write, T_PHASE=5, dir_in=0x21, data_in=0x45, escribe=1 held:
  - wr_n low for cycles 1-5 with ad_out=0x21, a_d=0.
  - Gap with cs_n=1 for cycles 11-15.
  - wr_n low for cycles 16-20 with ad_out=0x45, a_d=1.
  - fin high only at cycle 26.
  - No second transaction while inputs are held.
- After that write, controller changes only dir_in and data_in to 0xF0/0xF0 with activa still 1 -> second transaction starts from REARM with ad_out=0xF0 in both phases, and a single fin pulse.
- Read at dir_in=0x42 with ad_in=0x37 during DATA_LO:
  - data_read=0x37 after the transaction.
  - ad_oe=0 throughout the data phase.
  - wr_n is pulsed only in the address phase.
- escribe=1 and lee=1 together with dir_in=0x43, data_in=0x10 -> write sequence; rd_n stays 1.
- reset asserted in DATA_LO of a write -> next edge gives cs_n=1, wr_n=1, ad_oe=0, and fin never pulses; a new request after reset completes normally.
